// File: rtl/alu_if.sv
// Issue and broadcast signals between the reservation station, the ALU
// and the common data bus.
interface alu_if;
    logic        alu_en;
    logic [6:0]  alu_opcode;
    logic [2:0]  alu_func3;
    logic        alu_func1;
    logic [31:0] alu_val1;
    logic [31:0] alu_val2;
    logic [31:0] alu_imm;
    logic [31:0] alu_pc;
    logic [3:0]  alu_rob_pos;
    logic        cdb_stall;
    logic        alu_full;
    logic        result;
    logic [3:0]  result_rob_pos;
    logic [31:0] result_val;
    logic        result_jump;
    logic [31:0] result_pc;

    modport master (
        output alu_en, alu_opcode, alu_func3, alu_func1, alu_val1, alu_val2,
               alu_imm, alu_pc, alu_rob_pos, cdb_stall,
        input  alu_full, result, result_rob_pos, result_val, result_jump, result_pc
    );

    modport slave (
        input  alu_en, alu_opcode, alu_func3, alu_func1, alu_val1, alu_val2,
               alu_imm, alu_pc, alu_rob_pos, cdb_stall,
        output alu_full, result, result_rob_pos, result_val, result_jump, result_pc
    );
endinterface

// File: rtl/alu_unit.sv
// RV32I integer ALU: single-cycle execute feeding a 2-entry result queue
// that broadcasts its head entry to the common data bus.
module alu_unit (
    input  logic clk,
    input  logic rst,
    input  logic rdy,
    input  logic rollback,
    alu_if.slave bus
);
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;

    typedef struct packed {
        logic [3:0]  rob_pos;
        logic [31:0] val;
        logic        jump;
        logic [31:0] target;
    } entry_t;

    entry_t      fifo [2];
    entry_t      new_entry;
    logic        wr_ptr, rd_ptr;
    logic [1:0]  count;
    logic [31:0] op2;
    logic [31:0] pc_plus4;
    logic        taken;
    logic        do_push, do_pop;

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // through the case statements can leave one unassigned and infer a latch.
        new_entry         = '0;
        new_entry.rob_pos = bus.alu_rob_pos;
        pc_plus4          = bus.alu_pc + 32'd4;
        new_entry.target  = pc_plus4;
        op2               = (bus.alu_opcode == OPC_OP) ? bus.alu_val2 : bus.alu_imm;
        taken             = 1'b0;

        unique case (bus.alu_opcode)
            OPC_LUI:   new_entry.val = bus.alu_imm;
            OPC_AUIPC: new_entry.val = bus.alu_pc + bus.alu_imm;
            OPC_JAL: begin
                new_entry.val    = pc_plus4;
                new_entry.target = bus.alu_pc + bus.alu_imm;
                new_entry.jump   = 1'b1;
            end
            OPC_JALR: begin
                new_entry.val    = pc_plus4;
                new_entry.target = (bus.alu_val1 + bus.alu_imm) & ~32'd1;
                new_entry.jump   = 1'b1;
            end
            OPC_BRANCH: begin
                case (bus.alu_func3)
                    3'b000:  taken = (bus.alu_val1 == bus.alu_val2);
                    3'b001:  taken = (bus.alu_val1 != bus.alu_val2);
                    3'b100:  taken = ($signed(bus.alu_val1) <  $signed(bus.alu_val2));
                    3'b101:  taken = ($signed(bus.alu_val1) >= $signed(bus.alu_val2));
                    3'b110:  taken = (bus.alu_val1 <  bus.alu_val2);
                    3'b111:  taken = (bus.alu_val1 >= bus.alu_val2);
                    default: taken = 1'b0;
                endcase
                if (taken) begin
                    new_entry.jump   = 1'b1;
                    new_entry.target = bus.alu_pc + bus.alu_imm;
                end
            end
            OPC_OP, OPC_OPIMM: begin
                unique case (bus.alu_func3)
                    // Only register-register form uses func1 to select SUB.
                    3'b000: new_entry.val = (bus.alu_opcode == OPC_OP && bus.alu_func1)
                                            ? bus.alu_val1 - op2 : bus.alu_val1 + op2;
                    3'b001: new_entry.val = bus.alu_val1 << op2[4:0];
                    3'b010: new_entry.val = {31'd0, $signed(bus.alu_val1) < $signed(op2)};
                    3'b011: new_entry.val = {31'd0, bus.alu_val1 < op2};
                    3'b100: new_entry.val = bus.alu_val1 ^ op2;
                    3'b101: new_entry.val = bus.alu_func1
                                            ? 32'($signed(bus.alu_val1) >>> op2[4:0])
                                            : bus.alu_val1 >> op2[4:0];
                    3'b110: new_entry.val = bus.alu_val1 | op2;
                    3'b111: new_entry.val = bus.alu_val1 & op2;
                endcase
            end
            default: ;
        endcase
    end

    // A full queue still accepts an issue in the cycle its head retires.
    assign do_pop  = rdy && !rollback && (count != 2'd0) && !bus.cdb_stall;
    assign do_push = rdy && !rollback && bus.alu_en && ((count != 2'd2) || do_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: the two storage entries are reset because the outputs show
            // the head entry directly and must read as zero out of reset.
            fifo[0] <= '0;
            fifo[1] <= '0;
            wr_ptr  <= 1'b0;
            rd_ptr  <= 1'b0;
            count   <= 2'd0;
        end else if (rdy) begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values regardless of statement order.
            if (rollback) begin
                wr_ptr <= 1'b0;
                rd_ptr <= 1'b0;
                count  <= 2'd0;
            end else begin
                if (do_push) begin
                    fifo[wr_ptr] <= new_entry;
                    wr_ptr       <= ~wr_ptr;
                end
                if (do_pop) rd_ptr <= ~rd_ptr;
                count <= count + {1'b0, do_push} - {1'b0, do_pop};
            end
        end
    end

    assign bus.alu_full       = (count != 2'd0);
    assign bus.result         = (count != 2'd0);
    assign bus.result_rob_pos = fifo[rd_ptr].rob_pos;
    assign bus.result_val     = fifo[rd_ptr].val;
    assign bus.result_jump    = fifo[rd_ptr].jump;
    assign bus.result_pc      = fifo[rd_ptr].target;
endmodule

// File: tb/tb_alu_unit.sv
// Self-checking bench for alu_unit: directed scenarios plus randomized traffic
// compared against a queue-based behavioural model.
module tb_alu_unit;
    logic clk, rst, rdy, rollback;
    alu_if bus ();

    alu_unit dut (.clk(clk), .rst(rst), .rdy(rdy), .rollback(rollback), .bus(bus));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        v;
        logic        full;
        logic [3:0]  rob;
        logic [31:0] val;
        logic        jump;
        logic [31:0] pc;
    } out_t;

    typedef struct {
        logic [3:0]  rob;
        logic [31:0] val;
        logic        jump;
        logic [31:0] pc;
    } ent_t;

    ent_t model_q[$];
    int   n_pass = 0;
    int   n_total = 0;

    function automatic out_t observed();
        return '{bus.result, bus.alu_full, bus.result_rob_pos, bus.result_val,
                 bus.result_jump, bus.result_pc};
    endfunction

    function automatic out_t expect_head();
        if (model_q.size() == 0) return '0;
        return '{1'b1, 1'b1, model_q[0].rob, model_q[0].val, model_q[0].jump, model_q[0].pc};
    endfunction

    // Architectural meaning of each instruction, straight from the ISA rules.
    function automatic ent_t ref_exec(logic [6:0] opc, logic [2:0] f3, logic f1,
                                      logic [31:0] a, logic [31:0] b, logic [31:0] imm,
                                      logic [31:0] pc, logic [3:0] rob);
        ent_t e;
        longint sa, sb;
        logic [31:0] y;
        e = '{rob, 32'd0, 1'b0, pc + 32'd4};
        if (opc == 7'b0110111) e.val = imm;
        else if (opc == 7'b0010111) e.val = pc + imm;
        else if (opc == 7'b1101111) begin e.val = pc + 4; e.pc = pc + imm; e.jump = 1; end
        else if (opc == 7'b1100111) begin
            e.val = pc + 4; e.pc = a + imm; e.pc[0] = 1'b0; e.jump = 1;
        end else if (opc == 7'b1100011) begin
            sa = longint'($signed(a)); sb = longint'($signed(b));
            case (f3)
                3'd0: e.jump = (a == b);
                3'd1: e.jump = (a != b);
                3'd4: e.jump = (sa < sb);
                3'd5: e.jump = (sa >= sb);
                3'd6: e.jump = ({32'd0, a} < {32'd0, b});
                3'd7: e.jump = ({32'd0, a} >= {32'd0, b});
                default: e.jump = 0;
            endcase
            if (e.jump) e.pc = pc + imm;
        end else if (opc == 7'b0110011 || opc == 7'b0010011) begin
            y = (opc == 7'b0110011) ? b : imm;
            sa = longint'($signed(a)); sb = longint'($signed(y));
            case (f3)
                3'd0: e.val = (opc == 7'b0110011 && f1) ? a - y : a + y;
                3'd1: e.val = 32'(64'(a) * (64'd1 << y[4:0]));
                3'd2: e.val = (sa < sb) ? 32'd1 : 32'd0;
                3'd3: e.val = ({32'd0, a} < {32'd0, y}) ? 32'd1 : 32'd0;
                3'd4: e.val = a ^ y;
                3'd5: e.val = f1 ? 32'(sa / (longint'(1) << y[4:0]) - ((sa < 0 && (sa % (longint'(1) << y[4:0])) != 0) ? 1 : 0))
                                 : 32'({32'd0, a} / (64'd1 << y[4:0]));
                3'd6: e.val = a | y;
                3'd7: e.val = a & y;
            endcase
        end
        return e;
    endfunction

    // Advance one clock: update the model from the inputs about to be sampled.
    task automatic step();
        bit pop;
        if (!rst && rdy) begin
            if (rollback) model_q.delete();
            else begin
                pop = (model_q.size() != 0) && !bus.cdb_stall;
                if (pop) void'(model_q.pop_front());
                if (bus.alu_en && model_q.size() < 2)
                    model_q.push_back(ref_exec(bus.alu_opcode, bus.alu_func3, bus.alu_func1,
                                               bus.alu_val1, bus.alu_val2, bus.alu_imm,
                                               bus.alu_pc, bus.alu_rob_pos));
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic issue(logic [6:0] opc, logic [2:0] f3, logic f1, logic [31:0] a,
                         logic [31:0] b, logic [31:0] imm, logic [31:0] pc, logic [3:0] rob);
        bus.alu_en = 1; bus.alu_opcode = opc; bus.alu_func3 = f3; bus.alu_func1 = f1;
        bus.alu_val1 = a; bus.alu_val2 = b; bus.alu_imm = imm; bus.alu_pc = pc;
        bus.alu_rob_pos = rob;
    endtask

    task automatic idle();
        bus.alu_en = 0; rollback = 0;
    endtask

    task automatic test_reset();
        out_t o;
        rst = 1; rdy = 1; rollback = 0; bus.cdb_stall = 0;
        issue(7'b0110011, 3'd0, 0, 32'd1, 32'd2, 32'd0, 32'd0, 4'd5);
        bus.alu_en = 0;
        repeat (2) @(posedge clk);
        #1;
        o = observed();
        n_total++;
        if (o !== out_t'(0)) $display("FAIL reset_outputs got %h want 0", o); else n_pass++;
        rst = 0;
    endtask

    task automatic test_directed();
        out_t o;
        issue(7'b0110011, 3'd0, 0, 32'd5, 32'd7, 32'd0, 32'h200, 4'd3);
        step(); idle();
        o = observed();
        n_total++;
        if (o !== out_t'{1, 1, 4'd3, 32'd12, 0, 32'h204}) $display("FAIL add got %h", o); else n_pass++;
        step();
        n_total++;
        if ({bus.result, bus.alu_full} !== 2'b00) $display("FAIL add_retire got %b want 00", {bus.result, bus.alu_full}); else n_pass++;

        issue(7'b1100011, 3'd4, 0, 32'hFFFF_FFFF, 32'd1, 32'h20, 32'h100, 4'd6);
        step();
        issue(7'b1100011, 3'd6, 0, 32'hFFFF_FFFF, 32'd1, 32'h20, 32'h100, 4'd7);
        o = observed();
        n_total++;
        if ({o.jump, o.pc} !== {1'b1, 32'h120}) $display("FAIL blt got jump=%b pc=%h want 1/120", o.jump, o.pc); else n_pass++;
        step();
        issue(7'b1100111, 3'd0, 0, 32'h1001, 32'd0, 32'd2, 32'h40, 4'd8);
        o = observed();
        n_total++;
        if ({o.jump, o.pc} !== {1'b0, 32'h104}) $display("FAIL bltu got jump=%b pc=%h want 0/104", o.jump, o.pc); else n_pass++;
        step(); idle();
        o = observed();
        n_total++;
        if (o !== out_t'{1, 1, 4'd8, 32'h44, 1, 32'h1002}) $display("FAIL jalr got %h", o); else n_pass++;
        step();
    endtask

    task automatic test_back_to_back();
        out_t o;
        bus.cdb_stall = 1;
        issue(7'b0010011, 3'd0, 0, 32'd10, 32'd0, 32'd1, 32'h300, 4'd1);
        step();
        issue(7'b0010011, 3'd0, 0, 32'd20, 32'd0, 32'd2, 32'h304, 4'd2);
        n_total++;
        if ({bus.alu_full, bus.result_rob_pos} !== {1'b1, 4'd1}) $display("FAIL stall_first got %b/%0d", bus.alu_full, bus.result_rob_pos); else n_pass++;
        step(); idle();
        step();
        o = observed();
        n_total++;
        if (o !== out_t'{1, 1, 4'd1, 32'd11, 0, 32'h304}) $display("FAIL stall_held got %h", o); else n_pass++;
        bus.cdb_stall = 0;
        step();
        o = observed();
        n_total++;
        if (o !== out_t'{1, 1, 4'd2, 32'd22, 0, 32'h308}) $display("FAIL stall_second got %h", o); else n_pass++;
        step();
        n_total++;
        if (bus.result !== 1'b0) $display("FAIL stall_drain got %b want 0", bus.result); else n_pass++;
    endtask

    task automatic test_rollback();
        out_t o;
        bus.cdb_stall = 1;
        issue(7'b0110111, 3'd0, 0, 0, 0, 32'hAAAA_0000, 32'h0, 4'd4);
        step(); step();
        issue(7'b0110111, 3'd0, 0, 0, 0, 32'h5555_0000, 32'h0, 4'd9);
        rollback = 1;
        step(); idle();
        n_total++;
        if ({bus.result, bus.alu_full} !== 2'b00) $display("FAIL rollback got %b want 00", {bus.result, bus.alu_full}); else n_pass++;
        bus.cdb_stall = 0;
        issue(7'b0110011, 3'd0, 1, 32'd3, 32'd5, 32'd0, 32'h10, 4'd12);
        step(); idle();
        o = observed();
        n_total++;
        if (o !== out_t'{1, 1, 4'd12, 32'hFFFF_FFFE, 0, 32'h14}) $display("FAIL after_rollback got %h", o); else n_pass++;
        step();
    endtask

    task automatic test_rdy_hold();
        out_t o;
        issue(7'b0010111, 3'd0, 0, 0, 0, 32'h1000, 32'h80, 4'd14);
        step(); idle();
        rdy = 0;
        for (int i = 0; i < 2; i++) begin
            step();
            o = observed();
            n_total++;
            if (o !== out_t'{1, 1, 4'd14, 32'h1080, 0, 32'h84}) $display("FAIL rdy_hold%0d got %h", i, o); else n_pass++;
        end
        rdy = 1;
        step();
        n_total++;
        if (bus.result !== 1'b0) $display("FAIL rdy_retire got %b want 0", bus.result); else n_pass++;
    endtask

    task automatic test_reset_mid();
        out_t o;
        bus.cdb_stall = 1;
        issue(7'b0110111, 3'd0, 0, 0, 0, 32'hDEAD_B000, 0, 4'd7);
        step(); step(); idle();
        rst = 1;
        model_q.delete();
        #1;
        o = observed();
        n_total++;
        if (o !== out_t'(0)) $display("FAIL mid_reset got %h want 0", o); else n_pass++;
        #1 rst = 0;
        bus.cdb_stall = 0;
        issue(7'b0110011, 3'd7, 0, 32'hF0F0, 32'h0FF0, 0, 32'h20, 4'd2);
        step(); idle();
        o = observed();
        n_total++;
        if (o !== out_t'{1, 1, 4'd2, 32'h00F0, 0, 32'h24}) $display("FAIL post_reset got %h", o); else n_pass++;
        step();
    endtask

    task automatic test_random();
        logic [6:0] opcs [7] = '{7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111,
                                 7'b1100011, 7'b0110011, 7'b0010011};
        logic [6:0] opc;
        logic [31:0] a;
        out_t o, e;
        for (int i = 0; i < 400; i++) begin
            int k = $urandom_range(0, 7);
            opc = (k == 7) ? 7'($urandom) : opcs[k];
            a = $urandom;
            issue(opc, 3'($urandom), 1'($urandom), a, ($urandom_range(0, 3) == 0) ? a : $urandom,
                  $urandom, $urandom & 32'hFFFF_FFFC, 4'($urandom));
            bus.alu_en    = ($urandom_range(0, 9) < 6);
            bus.cdb_stall = ($urandom_range(0, 9) < 3);
            rdy           = ($urandom_range(0, 9) != 0);
            rollback      = ($urandom_range(0, 19) == 0);
            step();
            o = observed();
            e = expect_head();
            n_total++;
            if (e.v ? (o !== e) : ({o.v, o.full} !== 2'b00))
                $display("FAIL random[%0d] got %h want %h", i, o, e);
            else n_pass++;
        end
        rdy = 1; idle(); bus.cdb_stall = 0;
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_rollback();
        test_rdy_hold();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
